// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the machine-mode CSR access sequencer:
//   CSR address map, instruction op encoding, sequencer state encoding and
//   default widths.
// ----------------------------------------------------------------------------
package csr_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int CSR_ADDR_W_DEF = 12;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        OP_ILL = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RMW,
        S_RESP,
        S_T_EPC,
        S_T_CAUSE,
        S_T_VEC,
        S_T_CAP,
        S_T_RESP
    } seq_state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// ----------------------------------------------------------------------------
// csr_rmw_alu
//   Combinational read-modify-write datapath for one CSR instruction.
//   Ports:
//     op       : instruction op (RW/RS/RC, 00 is illegal)
//     old_val  : current CSR contents
//     src      : rs1 value or zero-extended zimm
//     src_zero : rs1 index / zimm is zero (set/clear forms then do not write)
//     addr     : CSR address (top two bits 11 mark a read-only CSR)
//     new_val  : value to write back
//     we       : write strobe request (never set for illegal accesses)
//     illegal  : op 00, or a write pending to a read-only CSR
// ----------------------------------------------------------------------------
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int CSR_ADDR_W = CSR_ADDR_W_DEF
) (
    input  csr_op_e               op,
    input  logic [XLEN-1:0]       old_val,
    input  logic [XLEN-1:0]       src,
    input  logic                  src_zero,
    input  logic [CSR_ADDR_W-1:0] addr,
    output logic [XLEN-1:0]       new_val,
    output logic                  we,
    output logic                  illegal
);

    logic wr_req;
    logic read_only;

    assign read_only = (addr >> (CSR_ADDR_W - 2)) == CSR_ADDR_W'(2'b11);

    always_comb begin
        new_val = old_val;
        wr_req  = 1'b0;
        case (op)
            OP_RW: begin
                new_val = src;
                wr_req  = 1'b1;
            end
            OP_RS: begin
                new_val = old_val | src;
                wr_req  = !src_zero;
            end
            OP_RC: begin
                new_val = old_val & ~src;
                wr_req  = !src_zero;
            end
            default: ;
        endcase
    end

    // A set/clear with a zero source is a pure read, so it is legal even on
    // read-only CSRs.
    assign illegal = (op == OP_ILL) || (read_only && wr_req);
    assign we      = wr_req && !illegal;

endmodule

// File: rtl/csr_access_seq.sv
// ----------------------------------------------------------------------------
// csr_access_seq
//   Sequencer in front of the machine CSR register file. Turns CSR
//   instructions into read / read-modify-write strobe sequences and trap
//   entries into mepc write, mcause write, mtvec fetch.
//
//   Optional feature macro: CSR_VECTORED_EN
//     defined   : mtvec mode 01 with an interrupt cause vectors to
//                 base + 4*cause[30:0]
//     undefined : direct mode only, the handler PC is always the mtvec base
//
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     req_*  (valid/ready/op/addr/src/src_zero)   CSR instruction in
//     resp_* (valid/ready/rdata/illegal)          old CSR value to rd
//     exc_*  (valid/ready/cause/pc)               trap-entry request in
//     trap_* (valid/ready/pc)                     handler PC to fetch
//     csr_addr_o/we_o/re_o/wdata_o/except_o        strobes to CSR file
//     csr_rdata_i                   CSR file read data, valid the cycle
//                                   after a read strobe
// ----------------------------------------------------------------------------
module csr_access_seq
    import csr_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int CSR_ADDR_W = CSR_ADDR_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [CSR_ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]       req_src_i,
    input  logic                  req_src_zero_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [XLEN-1:0]       resp_rdata_o,
    output logic                  resp_illegal_o,
    input  logic                  exc_valid_i,
    output logic                  exc_ready_o,
    input  logic [XLEN-1:0]       exc_cause_i,
    input  logic [XLEN-1:0]       exc_pc_i,
    output logic                  trap_valid_o,
    input  logic                  trap_ready_i,
    output logic [XLEN-1:0]       trap_pc_o,
    output logic [31:0]           csr_addr_o,
    output logic                  csr_we_o,
    output logic                  csr_re_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    output logic                  csr_except_o,
    input  logic [XLEN-1:0]       csr_rdata_i
);

    seq_state_e            state;
    csr_op_e               op_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       src_q;
    logic                  src_zero_q;
    logic [XLEN-1:0]       cause_q;
    logic [XLEN-1:0]       epc_q;
    logic [XLEN-1:0]       old_q;
    logic                  illegal_q;
    logic [XLEN-1:0]       trap_pc_q;

    logic [XLEN-1:0]       alu_new;
    logic                  alu_we;
    logic                  alu_illegal;
    logic [XLEN-1:0]       trap_target;

    csr_rmw_alu #(
        .XLEN       (XLEN),
        .CSR_ADDR_W (CSR_ADDR_W)
    ) u_alu (
        .op       (op_q),
        .old_val  (csr_rdata_i),
        .src      (src_q),
        .src_zero (src_zero_q),
        .addr     (addr_q),
        .new_val  (alu_new),
        .we       (alu_we),
        .illegal  (alu_illegal)
    );

    // Handler PC from the mtvec value returned in T_CAP.
    always_comb begin
        trap_target = csr_rdata_i & ~XLEN'(3);
`ifdef CSR_VECTORED_EN
        if (csr_rdata_i[1:0] == MTVEC_MODE_VECTORED && cause_q[XLEN-1])
            trap_target = trap_target + (cause_q << 2);
`endif
    end

    // Held low during reset so nothing is accepted while the block is held.
    assign exc_ready_o = rst_ni && (state == S_IDLE);
    assign req_ready_o = rst_ni && (state == S_IDLE) && !exc_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            op_q       <= OP_ILL;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
            trap_pc_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_valid_i) begin
                        cause_q <= exc_cause_i;
                        epc_q   <= exc_pc_i & ~XLEN'(3);
                        state   <= S_T_EPC;
                    end else if (req_valid_i) begin
                        op_q       <= csr_op_e'(req_op_i);
                        addr_q     <= req_addr_i;
                        src_q      <= req_src_i;
                        src_zero_q <= req_src_zero_i;
                        state      <= S_RD;
                    end
                end
                S_RD:  state <= S_RMW;
                S_RMW: begin
                    old_q     <= alu_illegal ? '0 : csr_rdata_i;
                    illegal_q <= alu_illegal;
                    state     <= S_RESP;
                end
                S_RESP:    if (resp_ready_i) state <= S_IDLE;
                S_T_EPC:   state <= S_T_CAUSE;
                S_T_CAUSE: state <= S_T_VEC;
                S_T_VEC:   state <= S_T_CAP;
                S_T_CAP: begin
                    trap_pc_q <= trap_target;
                    state     <= S_T_RESP;
                end
                S_T_RESP:  if (trap_ready_i) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the state register: reset clears them at once,
    // and the RMW write data has to follow the read data returned that cycle.
    always_comb begin
        csr_addr_o   = '0;
        csr_we_o     = 1'b0;
        csr_re_o     = 1'b0;
        csr_wdata_o  = '0;
        csr_except_o = 1'b0;
        case (state)
            S_RD: begin
                csr_addr_o = 32'(addr_q);
                csr_re_o   = 1'b1;
            end
            S_RMW: begin
                csr_addr_o  = 32'(addr_q);
                csr_we_o    = alu_we;
                csr_wdata_o = alu_we ? alu_new : '0;
            end
            S_T_EPC: begin
                csr_addr_o  = 32'(CSR_MEPC);
                csr_we_o    = 1'b1;
                csr_wdata_o = epc_q;
            end
            S_T_CAUSE: begin
                csr_addr_o  = 32'(CSR_MCAUSE);
                csr_we_o    = 1'b1;
                csr_wdata_o = cause_q;
            end
            S_T_VEC: begin
                csr_addr_o   = 32'(CSR_MTVEC);
                csr_re_o     = 1'b1;
                csr_except_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign resp_valid_o   = (state == S_RESP);
    assign resp_rdata_o   = old_q;
    assign resp_illegal_o = illegal_q;
    assign trap_valid_o   = (state == S_T_RESP);
    assign trap_pc_o      = trap_pc_q;

endmodule
